rpn_program_loader: RTL and testbench



---
 rtl/rpn_program_loader.sv | 131 +++++++++++++
 tb/tb_rpn_program_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_program_loader.sv
// Program loader for the RPN calculator sequencer: packs a framed byte stream
// into N-bit code words, writes them, starts the program and captures the result.
module rpn_program_loader #(
  parameter int N  = 16,
  parameter int M  = 10,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  seq_datain,
  output logic [M-1:0]  seq_addr,
  output logic          seq_wr,
  output logic          seq_start,
  input  logic          seq_ready,
  input  logic [N-1:0]  seq_out,
  output logic [N-1:0]  result,
  output logic [CW-1:0] cycles,
  output logic          res_valid,
  input  logic          res_ack
);

  localparam int B   = N / 8;
  localparam int BCW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_WRITE, S_START, S_RUN, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [BCW-1:0] byte_cnt;
  logic [N-1:0]   word;
  logic [M-1:0]   addr;
  logic [M:0]     remaining;
  logic           seen_busy;

  logic           accept;
  logic           last_byte;
  logic [N-1:0]   assembled;
  logic [M:0]     hdr_len;

  // Big-endian packing: each new byte enters at the bottom and older bytes
  // shift up, so the first byte of a word ends in the top byte lane.
  assign assembled  = N'({word, in_data});
  assign hdr_len    = (M + 1)'(assembled);
  assign last_byte  = (byte_cnt == BCW'(B - 1));
  assign accept     = in_valid && in_ready;
  assign seq_datain = word;
  assign seq_addr   = addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_HDR;
    else       state <= state_nx;
  end

  // NOTE: defaults at the top of every combinational block prevent latches.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_HDR:   if (accept && last_byte) state_nx = (hdr_len == '0) ? S_START : S_LOAD;
      S_LOAD:  if (accept && last_byte) state_nx = S_WRITE;
      S_WRITE: if (seq_ready) state_nx = (remaining == (M + 1)'(1)) ? S_START : S_LOAD;
      S_START: state_nx = S_RUN;
      S_RUN:   if (seq_ready && seen_busy) state_nx = S_DONE;
      S_DONE:  if (res_ack) state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  // in_ready is qualified by nrst so it reads low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    seq_wr    = 1'b0;
    seq_start = 1'b0;
    unique case (state)
      S_HDR:   in_ready  = seq_ready && nrst;
      S_LOAD:  in_ready  = 1'b1;
      S_WRITE: seq_wr    = seq_ready;
      S_START: seq_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byte_cnt  <= '0;
      word      <= '0;
      addr      <= '0;
      remaining <= '0;
      seen_busy <= 1'b0;
      result    <= '0;
      cycles    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        word     <= assembled;
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end
      unique case (state)
        S_HDR: if (accept && last_byte) begin
          remaining <= hdr_len;
          addr      <= '0;
        end
        S_WRITE: if (seq_ready) begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        S_START: begin
          cycles    <= '0;
          seen_busy <= 1'b0;
        end
        S_RUN: begin
          if (!seq_ready) begin
            seen_busy <= 1'b1;
            if (cycles != '1) cycles <= cycles + 1'b1;
          end else if (seen_busy) begin
            result    <= seq_out;
            res_valid <= 1'b1;
          end
        end
        S_DONE: if (res_ack) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_program_loader.sv
// Self-checking bench for rpn_program_loader: a default instance (N=16, M=10)
// and a small-address instance (M=2) for wrap-around, each with a sequencer model.
module tb_rpn_program_loader;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Shared stimulus, steered to one instance by sel
  int          sel = 0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        res_ack = 1'b0;
  int          busy_len = 1;
  logic [15:0] out_val = '0;

  // Default instance
  logic        a_in_ready, a_seq_wr, a_seq_start, a_res_valid;
  logic [15:0] a_seq_datain, a_result;
  logic [9:0]  a_seq_addr;
  logic [31:0] a_cycles;
  logic        a_rdy;
  logic [15:0] a_out;
  int          a_cnt;

  rpn_program_loader #(.N(16), .M(10), .CW(32)) dut (
    .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid && sel == 0),
    .in_ready(a_in_ready), .seq_datain(a_seq_datain), .seq_addr(a_seq_addr),
    .seq_wr(a_seq_wr), .seq_start(a_seq_start), .seq_ready(a_rdy), .seq_out(a_out),
    .result(a_result), .cycles(a_cycles), .res_valid(a_res_valid),
    .res_ack(res_ack && sel == 0)
  );

  // Small-address instance
  logic        s_in_ready, s_seq_wr, s_seq_start, s_res_valid;
  logic [15:0] s_seq_datain, s_result;
  logic [1:0]  s_seq_addr;
  logic [31:0] s_cycles;
  logic        s_rdy;
  logic [15:0] s_out;
  int          s_cnt;

  rpn_program_loader #(.N(16), .M(2), .CW(32)) dut_s (
    .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid && sel == 1),
    .in_ready(s_in_ready), .seq_datain(s_seq_datain), .seq_addr(s_seq_addr),
    .seq_wr(s_seq_wr), .seq_start(s_seq_start), .seq_ready(s_rdy), .seq_out(s_out),
    .result(s_result), .cycles(s_cycles), .res_valid(s_res_valid),
    .res_ack(res_ack && sel == 1)
  );

  // Sequencer models: busy for busy_len cycles after start, then ready with out_val
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_rdy <= 1'b1; a_cnt <= 0; a_out <= 16'hDEAD;
    end else if (a_seq_start) begin
      a_rdy <= 1'b0; a_cnt <= busy_len; a_out <= 16'hDEAD;
    end else if (a_cnt == 1) begin
      a_rdy <= 1'b1; a_cnt <= 0; a_out <= out_val;
    end else if (a_cnt > 1) begin
      a_cnt <= a_cnt - 1;
    end
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_rdy <= 1'b1; s_cnt <= 0; s_out <= 16'hDEAD;
    end else if (s_seq_start) begin
      s_rdy <= 1'b0; s_cnt <= busy_len; s_out <= 16'hDEAD;
    end else if (s_cnt == 1) begin
      s_rdy <= 1'b1; s_cnt <= 0; s_out <= out_val;
    end else if (s_cnt > 1) begin
      s_cnt <= s_cnt - 1;
    end
  end

  // Monitor view of the selected instance
  logic        m_in_ready, m_wr, m_start, m_rdy, m_res_valid;
  logic [9:0]  m_addr;
  logic [15:0] m_data, m_result;
  logic [31:0] m_cycles;
  assign m_in_ready  = sel ? s_in_ready  : a_in_ready;
  assign m_wr        = sel ? s_seq_wr    : a_seq_wr;
  assign m_start     = sel ? s_seq_start : a_seq_start;
  assign m_rdy       = sel ? s_rdy       : a_rdy;
  assign m_res_valid = sel ? s_res_valid : a_res_valid;
  assign m_addr      = sel ? {8'b0, s_seq_addr} : a_seq_addr;
  assign m_data      = sel ? s_seq_datain : a_seq_datain;
  assign m_result    = sel ? s_result     : a_result;
  assign m_cycles    = sel ? s_cycles     : a_cycles;

  // Scoreboard of expected code writes
  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  int acc_cyc = 0;
  int last_wr_cyc = 0;
  int rise_cyc = 0;
  int start_cnt = 0;
  bit frame_wr = 0;
  logic prev_rdy = 1'b1;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      if (m_wr) begin
        wr_t e;
        check("wr_in_ready_low", m_in_ready, 0);
        check("wr_no_start", m_start, 0);
        check("wr_latency", cyc, acc_cyc + 1);
        check("wr_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", m_addr, e.addr);
          check("wr_data", m_data, e.data);
        end
        last_wr_cyc = cyc;
        frame_wr = 1;
      end
      if (m_start) begin
        start_cnt++;
        check("start_latency", cyc, frame_wr ? last_wr_cyc + 1 : acc_cyc + 1);
      end
      if (m_rdy && !prev_rdy) rise_cyc = cyc;
      if (m_res_valid && !prev_valid) check("res_latency", cyc, rise_cyc + 1);
      prev_rdy = m_rdy;
      prev_valid = m_res_valid;
    end
  end

  // Tasks are entered and left 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    bit acc;
    int n;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data = b;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = m_in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap_max);
    send_byte(w[15:8], gap_max);
    send_byte(w[7:0], gap_max);
  endtask

  typedef struct {
    int          sel;
    int          gap;
    logic [15:0] hdr;
    int          nw;
    logic [15:0] w [6];
    int          busy;
    logic [15:0] out;
    int          hold;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n;
    sel = v.sel;
    busy_len = v.busy;
    out_val = v.out;
    frame_wr = 0;
    start_cnt = 0;
    send_word(v.hdr, v.gap);
    for (int i = 0; i < v.nw; i++) begin
      wr_t e;
      e.addr = (v.sel == 1) ? 10'(i % 4) : 10'(i % 1024);
      e.data = v.w[i];
      exp_q.push_back(e);
      send_word(v.w[i], v.gap);
    end
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_res_valid && n < 300) begin
      check("no_early_valid_in_ready", m_in_ready && m_res_valid, 0);
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", m_res_valid, 1);
    check("result", m_result, v.out);
    check("cycles", m_cycles, v.busy);
    check("wr_queue_empty", exp_q.size(), 0);
    check("start_once", start_cnt, 1);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("hold_valid", m_res_valid, 1);
      check("hold_result", m_result, v.out);
      check("hold_cycles", m_cycles, v.busy);
      check("hold_in_ready", m_in_ready, 0);
    end
    @(posedge clk); #1;
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    @(negedge clk);
    check("ack_clears_valid", m_res_valid, 0);
    check("ack_back_to_hdr", m_in_ready, 1);
    check("ack_result_held", m_result, v.out);
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{sel: 0, gap: 0, hdr: 16'h0003, nw: 3, w: '{16'h8002, 16'h0005, 16'hC000, 16'h0, 16'h0, 16'h0},
                busy: 7, out: 16'h002A, hold: 5};
    vecs[1] = '{sel: 0, gap: 4, hdr: 16'h0003, nw: 3, w: '{16'h8002, 16'h0005, 16'hC000, 16'h0, 16'h0, 16'h0},
                busy: 3, out: 16'h1234, hold: 1};
    vecs[2] = '{sel: 0, gap: 0, hdr: 16'h0000, nw: 0, w: '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                busy: 2, out: 16'hBEEF, hold: 0};
    vecs[3] = '{sel: 1, gap: 0, hdr: 16'h0004, nw: 4, w: '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0},
                busy: 1, out: 16'h0004, hold: 0};
    vecs[4] = '{sel: 1, gap: 2, hdr: 16'h0006, nw: 6, w: '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006},
                busy: 5, out: 16'h0006, hold: 2};

    // Reset state
    #12;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_seq_wr", a_seq_wr, 0);
    check("rst_seq_start", a_seq_start, 0);
    check("rst_seq_addr", a_seq_addr, 0);
    check("rst_seq_datain", a_seq_datain, 0);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_result", a_result, 0);
    check("rst_cycles", a_cycles, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of a load: header, one word, half of the next
    sel = 0;
    frame_wr = 0;
    exp_q.push_back('{addr: 10'd0, data: 16'h8002});
    send_word(16'h0003, 0);
    send_word(16'h8002, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    check("pre_rst_result_nonzero", a_result != 0, 1);
    #3;
    nrst = 1'b0;
    #1;
    check("arst_in_ready", a_in_ready, 0);
    check("arst_seq_wr", a_seq_wr, 0);
    check("arst_seq_start", a_seq_start, 0);
    check("arst_seq_addr", a_seq_addr, 0);
    check("arst_seq_datain", a_seq_datain, 0);
    check("arst_res_valid", a_res_valid, 0);
    check("arst_result", a_result, 0);
    check("arst_cycles", a_cycles, 0);
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
